// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared pipeline/bypass types and latency constants for issue control
package segre_pkg;

    localparam int REG_SIZE = 5;
    localparam int EX_LAT   = 1;
    localparam int RVM_LAT  = 5;

    typedef enum logic [1:0] {
        EX_PIPELINE  = 2'd0,
        MEM_PIPELINE = 2'd1,
        RVM_PIPELINE = 2'd2
    } pipeline_t;

    typedef enum logic [1:0] {
        NO_BYPASS    = 2'd0,
        BY_EX_PIPE   = 2'd1,
        BY_MEM_PIPE  = 2'd2,
        BY_RVM5_PIPE = 2'd3
    } bypass_t;

    // Bypass select matching the pipeline that produces the pending value
    function automatic bypass_t bypass_from(input pipeline_t p);
        case (p)
            EX_PIPELINE:  return BY_EX_PIPE;
            MEM_PIPELINE: return BY_MEM_PIPE;
            RVM_PIPELINE: return BY_RVM5_PIPE;
            default:      return NO_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/segre_scoreboard_entry.sv
// rtl/segre_scoreboard_entry.sv - pending/source/countdown state for one architectural register
module segre_scoreboard_entry
    import segre_pkg::*;
#(
    parameter int CNT_W       = 3,
    parameter int MAX_RVM_LAT = segre_pkg::RVM_LAT
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             mem_hit_i,
    input  logic             set_i,
    input  pipeline_t        set_src_i,
    input  logic [CNT_W-1:0] set_cnt_i,
    output logic             pend_o,
    output pipeline_t        src_o,
    output logic             ready_o
);

    logic             pend_q;
    pipeline_t        src_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_mem;

    assign is_mem  = (src_q == MEM_PIPELINE);
    // MEM results have variable latency and are only trusted when the writeback names us
    assign ready_o = pend_q && (is_mem ? mem_hit_i : (cnt_q == '0));
    assign pend_o  = pend_q;
    assign src_o   = src_q;

    // A new writer wins over the clear of the previous writer in the same cycle
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            pend_q <= 1'b0;
            src_q  <= EX_PIPELINE;
            cnt_q  <= '0;
        end else if (set_i) begin
            pend_q <= 1'b1;
            src_q  <= set_src_i;
            cnt_q  <= set_cnt_i;
        end else begin
            if (ready_o) begin
                pend_q <= 1'b0;
            end
            if (pend_q && !is_mem && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Countdown of a fixed-latency producer can never exceed the longest latency
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rsn_i)
        (pend_q && !is_mem) |-> (cnt_q <= CNT_W'(MAX_RVM_LAT - 1)));

endmodule

// File: rtl/segre_issue_scoreboard.sv
// rtl/segre_issue_scoreboard.sv - register scoreboard deciding issue, stalls and operand bypass selects
module segre_issue_scoreboard
    import segre_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int EX_LAT   = segre_pkg::EX_LAT,
    parameter int RVM_LAT  = segre_pkg::RVM_LAT,
    parameter int CNT_W    = 3
) (
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic                valid_i,
    input  pipeline_t           pipeline_i,
    input  logic                rf_we_i,
    input  logic [REG_SIZE-1:0] rf_waddr_i,
    input  logic                rs_a_used_i,
    input  logic                rs_b_used_i,
    input  logic [REG_SIZE-1:0] rs_a_i,
    input  logic [REG_SIZE-1:0] rs_b_i,
    input  logic                mem_busy_i,
    input  logic                mem_we_i,
    input  logic [REG_SIZE-1:0] mem_waddr_i,
    output logic                issue_o,
    output logic                stall_o,
    output bypass_t             bypass_a_o,
    output bypass_t             bypass_b_o
);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] ready;
    pipeline_t           src [NUM_REGS];
    logic [CNT_W-1:0]    set_cnt;
    logic                blk_a;
    logic                blk_b;
    logic                waw_blk;
    logic                struct_blk;

    // x0 is hardwired zero: never pending, so reads never bypass and writes never block
    assign pend[0]  = 1'b0;
    assign ready[0] = 1'b0;
    assign src[0]   = EX_PIPELINE;

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_entry
            segre_scoreboard_entry #(
                .CNT_W       (CNT_W),
                .MAX_RVM_LAT (RVM_LAT)
            ) u_entry (
                .clk_i     (clk_i),
                .rsn_i     (rsn_i),
                .mem_hit_i (mem_we_i && (mem_waddr_i == REG_SIZE'(r))),
                .set_i     (issue_o && rf_we_i && (rf_waddr_i == REG_SIZE'(r))),
                .set_src_i (pipeline_i),
                .set_cnt_i (set_cnt),
                .pend_o    (pend[r]),
                .src_o     (src[r]),
                .ready_o   (ready[r])
            );
        end
    endgenerate

    // Countdown loaded so that it hits zero in the cycle the result leaves its pipeline
    always_comb begin
        set_cnt = '0;
        case (pipeline_i)
            EX_PIPELINE:  set_cnt = CNT_W'(EX_LAT - 1);
            RVM_PIPELINE: set_cnt = CNT_W'(RVM_LAT - 1);
            default:      set_cnt = '0;
        endcase
    end

    // Source operands: pending and ready bypasses from the producer, pending and not ready blocks
    always_comb begin
        bypass_a_o = NO_BYPASS;
        bypass_b_o = NO_BYPASS;
        blk_a      = 1'b0;
        blk_b      = 1'b0;
        if (rs_a_used_i && pend[rs_a_i]) begin
            if (ready[rs_a_i]) begin
                bypass_a_o = bypass_from(src[rs_a_i]);
            end else begin
                blk_a = 1'b1;
            end
        end
        if (rs_b_used_i && pend[rs_b_i]) begin
            if (ready[rs_b_i]) begin
                bypass_b_o = bypass_from(src[rs_b_i]);
            end else begin
                blk_b = 1'b1;
            end
        end
    end

    // An older writer still in flight could retire after us, so wait until it is ready
    assign waw_blk    = rf_we_i && (rf_waddr_i != '0) && pend[rf_waddr_i] && !ready[rf_waddr_i];
    assign struct_blk = (pipeline_i == MEM_PIPELINE) && mem_busy_i;

    // Nothing issues while reset is held, since the pipelines are being flushed
    assign issue_o = rsn_i && valid_i && !blk_a && !blk_b && !waw_blk && !struct_blk;
    assign stall_o = valid_i && !issue_o;

    // A MEM writeback must always correspond to a load the scoreboard is tracking
    a_mem_we_tracked: assert property (@(posedge clk_i) disable iff (!rsn_i)
        (mem_we_i && (mem_waddr_i != '0)) |->
            (pend[mem_waddr_i] && (src[mem_waddr_i] == MEM_PIPELINE)));

endmodule

// File: tb/tb_segre_issue_scoreboard.sv
// tb/tb_segre_issue_scoreboard.sv - directed and random checks of the issue scoreboard against a timing model
module tb_segre_issue_scoreboard;
    import segre_pkg::*;

    logic        clk;
    logic        rsn;
    logic        valid;
    pipeline_t   pipeline;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        rs_a_used;
    logic        rs_b_used;
    logic [4:0]  rs_a;
    logic [4:0]  rs_b;
    logic        mem_busy;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic        issue;
    logic        stall;
    bypass_t     bypass_a;
    bypass_t     bypass_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a pending register knows its producer and the absolute cycle its result is available
    bit m_pend   [32];
    int m_pipe   [32];
    int m_tready [32];
    int cyc = 0;

    segre_issue_scoreboard dut (
        .clk_i       (clk),
        .rsn_i       (rsn),
        .valid_i     (valid),
        .pipeline_i  (pipeline),
        .rf_we_i     (rf_we),
        .rf_waddr_i  (rf_waddr),
        .rs_a_used_i (rs_a_used),
        .rs_b_used_i (rs_b_used),
        .rs_a_i      (rs_a),
        .rs_b_i      (rs_b),
        .mem_busy_i  (mem_busy),
        .mem_we_i    (mem_we),
        .mem_waddr_i (mem_waddr),
        .issue_o     (issue),
        .stall_o     (stall),
        .bypass_a_o  (bypass_a),
        .bypass_b_o  (bypass_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit m_ready(input int r);
        if (!m_pend[r]) return 1'b0;
        if (m_pipe[r] == 1) return mem_we && (int'(mem_waddr) == r);
        return cyc >= m_tready[r];
    endfunction

    function automatic int byp_of(input int p);
        return p + 1;
    endfunction

    task automatic model_eval(output bit iss, output int ba, output int bb);
        bit ok;
        ok = 1'b1;
        ba = 0;
        bb = 0;
        if (rs_a_used && rs_a != 0 && m_pend[rs_a]) begin
            if (m_ready(int'(rs_a))) ba = byp_of(m_pipe[rs_a]);
            else ok = 1'b0;
        end
        if (rs_b_used && rs_b != 0 && m_pend[rs_b]) begin
            if (m_ready(int'(rs_b))) bb = byp_of(m_pipe[rs_b]);
            else ok = 1'b0;
        end
        if (rf_we && rf_waddr != 0 && m_pend[rf_waddr] && !m_ready(int'(rf_waddr))) ok = 1'b0;
        if (pipeline == MEM_PIPELINE && mem_busy) ok = 1'b0;
        iss = rsn && valid && ok;
    endtask

    task automatic model_update(input bit iss);
        bit rdy [32];
        if (!rsn) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) rdy[r] = m_ready(r);
            for (int r = 0; r < 32; r++) if (rdy[r]) m_pend[r] = 1'b0;
            if (iss && rf_we && rf_waddr != 0) begin
                m_pend[rf_waddr]   = 1'b1;
                m_pipe[rf_waddr]   = int'(pipeline);
                m_tready[rf_waddr] = cyc + ((pipeline == RVM_PIPELINE) ? RVM_LAT : EX_LAT);
            end
        end
        cyc++;
    endtask

    task automatic drive(input bit v, input int p, input bit we, input int rd,
                         input bit ua, input int ra, input bit ub, input int rb,
                         input bit busy = 1'b0, input bit mwe = 1'b0, input int mwa = 0);
        valid     = v;
        pipeline  = pipeline_t'(p[1:0]);
        rf_we     = we;
        rf_waddr  = rd[4:0];
        rs_a_used = ua;
        rs_a      = ra[4:0];
        rs_b_used = ub;
        rs_b      = rb[4:0];
        mem_busy  = busy;
        mem_we    = mwe;
        mem_waddr = mwa[4:0];
        #1;
    endtask

    task automatic step();
        bit iss;
        int ba;
        int bb;
        model_eval(iss, ba, bb);
        check("issue", issue, iss);
        check("stall", stall, valid && !iss);
        if (iss) begin
            check("bypass_a", bypass_a, ba);
            check("bypass_b", bypass_b, bb);
        end
        @(posedge clk);
        model_update(iss);
        @(negedge clk);
    endtask

    initial begin
        int q[$];
        bit mwe;
        int mwa;

        rsn = 1'b0;
        drive(1, 0, 1, 5, 0, 0, 0, 0);
        check("rst_issue", issue, 0);
        check("rst_stall", stall, 1);
        step();
        step();
        @(negedge clk);
        rsn = 1'b1;

        // EX writer then EX reader next cycle
        drive(1, 0, 1, 5, 0, 0, 0, 0);
        check("ex_w_issue", issue, 1);
        step();
        drive(1, 0, 0, 0, 1, 5, 0, 0);
        check("ex_r_issue", issue, 1);
        check("ex_r_byp", bypass_a, BY_EX_PIPE);
        step();

        // RVM writer, dependent EX waits four cycles
        drive(1, 2, 1, 7, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 1, 7, 0, 0);
            check("rvm_raw_stall", stall, 1);
            step();
        end
        drive(1, 0, 0, 0, 1, 7, 0, 0);
        check("rvm_raw_issue", issue, 1);
        check("rvm_raw_byp", bypass_a, BY_RVM5_PIPE);
        step();

        // MEM load with busy MEM pipe, dependent EX waits for the writeback
        drive(1, 1, 1, 3, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 1, 3, 0, 0, 1);
            check("mem_raw_stall", stall, 1);
            step();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
        check("mem_busy_stall", stall, 1);
        step();
        drive(1, 0, 0, 0, 1, 3, 0, 0, 0, 1, 3);
        check("mem_raw_issue", issue, 1);
        check("mem_raw_byp", bypass_a, BY_MEM_PIPE);
        step();
        drive(1, 0, 0, 0, 1, 3, 0, 0);
        check("mem_clear_issue", issue, 1);
        check("mem_clear_byp", bypass_a, NO_BYPASS);
        step();

        // WAW: EX writer behind RVM writer of x9
        drive(1, 2, 1, 9, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 9, 0, 0, 0, 0);
            check("waw_stall", stall, 1);
            step();
        end
        drive(1, 0, 1, 9, 0, 0, 0, 0);
        check("waw_issue", issue, 1);
        step();
        drive(1, 0, 0, 0, 0, 0, 1, 9);
        check("waw_new_src", bypass_b, BY_EX_PIPE);
        step();

        // x0 writes and reads never interact
        drive(1, 2, 1, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 1, 0, 1, 0, 1, 0);
        check("x0_issue", issue, 1);
        check("x0_byp_a", bypass_a, NO_BYPASS);
        check("x0_byp_b", bypass_b, NO_BYPASS);
        step();

        // Reset while RVM x4 is in flight at cnt=2
        drive(1, 2, 1, 4, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rsn = 1'b0;
        drive(1, 0, 0, 0, 1, 4, 0, 0);
        check("midrst_issue", issue, 0);
        step();
        rsn = 1'b1;
        drive(1, 0, 0, 0, 1, 4, 0, 0);
        check("postrst_issue", issue, 1);
        check("postrst_byp", bypass_a, NO_BYPASS);
        step();

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            rsn = ($urandom % 400) != 0;
            q.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r] && m_pipe[r] == 1) q.push_back(r);
            mwe = 1'b0;
            mwa = 0;
            if (rsn && q.size() > 0 && ($urandom % 2) == 0) begin
                mwe = 1'b1;
                mwa = q[$urandom % q.size()];
            end
            drive(($urandom % 4) != 0, $urandom % 3, ($urandom % 4) != 0, $urandom % 8,
                  $urandom % 2, $urandom % 8, $urandom % 2, $urandom % 8,
                  ($urandom % 4) == 0, mwe, mwa);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
